dmem_responder: RTL and testbench

//  Data-memory responder for the load/store port of the single-cycle ARM datapath: consumes address
//  (ALUResult), store data (WriteData) and byte-select (DMSrc), returns ReadData. Adds a request/

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_unit.sv | 30 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding, lane geometry, access check.
package dmem_pkg;

    localparam int LANE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / LANE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned word accesses and anything past the last byte of the array are rejected.
    function automatic logic access_err(input logic is_byte, input logic [WORD_W-1:0] addr,
                                        input int depth_words);
        logic [WORD_W:0] limit;
        limit = 33'(depth_words) << 2;
        return (!is_byte && addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane steering: byte enables and lane-replicated write data for stores,
// selected-lane extract with zero extension for byte loads.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic              i_we,
    input  logic              i_byte,
    input  logic [1:0]        i_lane,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rword,
    output logic [LANES-1:0]  o_be,
    output logic [WORD_W-1:0] o_wlanes,
    output logic [WORD_W-1:0] o_rdata
);

    always_comb begin
        o_be     = '0;
        o_wlanes = i_wdata;
        o_rdata  = i_rword;
        if (i_byte) begin
            // Replicating the byte lets the array write each lane from its own slice.
            o_wlanes = {LANES{i_wdata[LANE_W-1:0]}};
            o_rdata  = {{(WORD_W-LANE_W){1'b0}}, i_rword[i_lane*LANE_W +: LANE_W]};
        end
        if (i_we) begin
            o_be = i_byte ? (LANES'(1) << i_lane) : {LANES{1'b1}};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store data memory with request/response handshake and LATENCY programmable wait states.
// One request outstanding; the array is touched exactly once, on the edge that enters RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_byte;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    logic              w_go_resp;
    logic              w_we;
    logic              w_byte;
    logic [WORD_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [LANES-1:0]  w_be;
    logic [WORD_W-1:0] w_wlanes;
    logic [WORD_W-1:0] w_lane_rdata;

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign w_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_byte  = (r_state == IDLE) ? req_byte  : r_byte;
    assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_err   = access_err(w_byte, w_addr, DEPTH_WORDS);
    assign w_idx   = w_addr[IDX_W+1:2];

    dmem_lane_unit u_lane (
        .i_we     (w_we),
        .i_byte   (w_byte),
        .i_lane   (w_addr[1:0]),
        .i_wdata  (w_wdata),
        .i_rword  (r_mem[w_idx]),
        .o_be     (w_be),
        .o_wlanes (w_wlanes),
        .o_rdata  (w_lane_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_go_resp   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LAT_CNT == 4'd0) begin
                        w_state_nxt = RESP;
                        w_go_resp   = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                    w_go_resp   = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= LAT_CNT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_go_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? '0 : w_lane_rdata;
            end
        end
    end

    // Storage is never reset; reset only blocks a commit that would land on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && w_go_resp && !w_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_be[i]) r_mem[w_idx][i*LANE_W +: LANE_W] <= w_wlanes[i*LANE_W +: LANE_W];
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance share stimulus.
module tb_dmem_responder;

    typedef struct {
        int          dut;
        int          due;
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid [2];
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata [2];
    logic        resp_err [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q[$];
    bit          seen [2];
    bit          chk_idle [2];
    logic [31:0] hold_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input bit ok, input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: latency on first sight of resp_valid, stability while stalled, data on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_idle[d]) begin
                chk_idle[d] = 1'b0;
                chk(req_ready[d] === 1'b1 && resp_valid[d] === 1'b0, "idle_after_resp", d,
                    {31'd0, req_ready[d]}, 32'd1);
            end
            if (!reset && resp_valid[d] === 1'b1) begin
                if (q.size() == 0 || q[0].dut != d) begin
                    chk(1'b0, "unexpected_resp", d, resp_rdata[d], 32'd0);
                end else begin
                    if (!seen[d]) begin
                        seen[d]    = 1'b1;
                        hold_rd[d] = resp_rdata[d];
                        chk(cyc == q[0].due, "latency", q[0].id, 32'(cyc), 32'(q[0].due));
                    end else begin
                        chk(resp_rdata[d] === hold_rd[d] && req_ready[d] === 1'b0, "stall_stable",
                            q[0].id, resp_rdata[d], hold_rd[d]);
                    end
                    if (resp_ready) begin
                        chk(resp_rdata[d] === q[0].rdata, "rdata", q[0].id, resp_rdata[d], q[0].rdata);
                        chk(resp_err[d] === q[0].err, "err", q[0].id, {31'd0, resp_err[d]},
                            {31'd0, q[0].err});
                        void'(q.pop_front());
                        seen[d]     = 1'b0;
                        chk_idle[d] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input bit we, input bit byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd, input bit eerr,
                         input bit push, input int id);
        int lat;
        lat = (d == 0) ? 2 : 0;
        @(negedge clk);
        req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata; req_valid[d] = 1'b1;
        for (int i = 0; i < 100 && req_ready[d] !== 1'b1; i++) @(negedge clk);
        if (req_ready[d] !== 1'b1) begin
            chk(1'b0, "accept_timeout", id, 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        if (push) q.push_back('{d, cyc + lat + 1, erd, eerr, id});
        @(posedge clk);
        #1;
        // Scramble the request after accept; the responder must use its latched copy.
        req_valid[d] = 1'b0; req_we = ~we; req_byte = ~byt;
        req_addr = 32'hFFFF_FFF1; req_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk(1'b0, "drain_timeout", q[0].id, 32'(q.size()), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d queued", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        seen[0] = 1'b0; seen[1] = 1'b0; chk_idle[0] = 1'b0; chk_idle[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk(req_ready[d] === 1'b1, "rst_req_ready", d, {31'd0, req_ready[d]}, 32'd1);
            chk(resp_valid[d] === 1'b0, "rst_resp_valid", d, {31'd0, resp_valid[d]}, 32'd0);
            chk(resp_rdata[d] === 32'd0, "rst_resp_rdata", d, resp_rdata[d], 32'd0);
            chk(resp_err[d] === 1'b0, "rst_resp_err", d, {31'd0, resp_err[d]}, 32'd0);
        end

        // Word store/load round trip
        issue(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, 1);
        issue(0, 0, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 1, 2);
        drain();

        // Byte store into an existing word, then word and byte loads
        issue(0, 1, 0, 32'h10, 32'h1122_3344, 32'h0, 0, 1, 3);
        issue(0, 1, 1, 32'h12, 32'hFFFF_FF5A, 32'h0, 0, 1, 4);
        issue(0, 0, 0, 32'h10, 32'h0, 32'h115A_3344, 0, 1, 5);
        issue(0, 0, 1, 32'h12, 32'h0, 32'h0000_005A, 0, 1, 6);
        issue(0, 0, 1, 32'h13, 32'h0, 32'h0000_0011, 0, 1, 7);
        drain();

        // Errors: misaligned word, out of range, and the last legal byte
        issue(0, 0, 0, 32'h13,  32'h0,         32'h0, 1, 1, 8);
        issue(0, 1, 0, 32'h100, 32'h1234_5678, 32'h0, 1, 1, 9);
        issue(0, 1, 1, 32'h100, 32'h0000_0077, 32'h0, 1, 1, 10);
        issue(0, 1, 0, 32'h12,  32'h0,         32'h0, 1, 1, 11);
        issue(0, 1, 0, 32'hFC,  32'hA1B2_C3D4, 32'h0, 0, 1, 12);
        issue(0, 0, 1, 32'hFF,  32'h0, 32'h0000_00A1, 0, 1, 13);
        issue(0, 0, 0, 32'h10,  32'h0, 32'h115A_3344, 0, 1, 14);
        drain();

        // Hold off the response for 5 cycles
        resp_ready = 1'b0;
        issue(0, 0, 0, 32'h10, 32'h0, 32'h115A_3344, 0, 1, 15);
        for (int i = 0; i < 50 && resp_valid[0] !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // Zero-wait-state instance
        issue(1, 1, 0, 32'h40, 32'h8765_4321, 32'h0, 0, 1, 16);
        issue(1, 0, 0, 32'h40, 32'h0, 32'h8765_4321, 0, 1, 17);
        issue(1, 0, 1, 32'h41, 32'h0, 32'h0000_0043, 0, 1, 18);
        issue(1, 0, 0, 32'h42, 32'h0, 32'h0, 1, 1, 19);
        drain();

        // Reset during WAIT discards the store
        issue(0, 1, 0, 32'h20, 32'h0, 32'h0, 0, 1, 20);
        drain();
        issue(0, 1, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 0, 21);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk(req_ready[0] === 1'b1, "abort_req_ready", 21, {31'd0, req_ready[0]}, 32'd1);
        chk(resp_valid[0] === 1'b0, "abort_resp_valid", 21, {31'd0, resp_valid[0]}, 32'd0);
        issue(0, 0, 0, 32'h20, 32'h0, 32'h0000_0000, 0, 1, 22);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
